// File: rtl/taxi_axi_if.sv
// AXI4 bus bundle shared by masters and responders.
// wr_* modports carry AW/W/B, rd_* modports carry AR/R.
interface taxi_axi_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned USER_W = 1,
    parameter int unsigned STRB_W = DATA_W / 8
);
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic [3:0]        awregion;
    logic [USER_W-1:0] awuser;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic [USER_W-1:0] wuser;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic [USER_W-1:0] buser;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic [3:0]        arregion;
    logic [USER_W-1:0] aruser;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [USER_W-1:0] ruser;
    logic              rvalid;
    logic              rready;

    modport wr_mst (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, buser, bvalid,
        output bready
    );

    modport wr_slv (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wuser, wvalid,
        output wready,
        output bid, bresp, buser, bvalid,
        input  bready
    );

    modport rd_mst (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

    modport rd_slv (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );
endinterface

// File: rtl/taxi_axi_ram.sv
// AXI4 responder backed by a byte-strobed dual-port RAM.
// Independent write and read FSMs, one burst in flight per channel.
module taxi_axi_ram #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    taxi_axi_if.wr_slv s_axi_wr,
    taxi_axi_if.rd_slv s_axi_rd
);
    localparam int unsigned DATA_W = s_axi_wr.DATA_W;
    localparam int unsigned ID_W   = s_axi_wr.ID_W;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned WORD_W = ADDR_W - OFF_W;
    localparam int unsigned WORDS  = 2 ** WORD_W;

    typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_BURST} r_state_e;

    // Beat-to-beat address step for FIXED/INCR/WRAP; odd WRAP lengths and 2'b11 fall back to INCR.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        logic              wrap_ok;
        step = ADDR_W'(1) << size;
        inc  = addr + step;
        mask = (ADDR_W'(len) + ADDR_W'(1)) << size;
        mask = mask - ADDR_W'(1);
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: wrap_ok = 1'b1;
            default:                 wrap_ok = 1'b0;
        endcase
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = wrap_ok ? ((addr & ~mask) | (inc & mask)) : inc;
            default: next_addr = inc;
        endcase
    endfunction

    logic [DATA_W-1:0] mem_q [WORDS];

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d;
    logic [2:0]        wsize_q, wsize_d;
    logic [1:0]        wburst_q, wburst_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic              mem_we_c;

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d;
    logic [7:0]        rcnt_q, rcnt_d;
    logic              rdone_q, rdone_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_re_c;

    // Write channel next-state
    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        mem_we_c  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_wr.awvalid && awready_q) begin
                    wid_d     = s_axi_wr.awid;
                    waddr_d   = ADDR_W'(s_axi_wr.awaddr);
                    wlen_d    = s_axi_wr.awlen;
                    wsize_d   = s_axi_wr.awsize;
                    wburst_d  = s_axi_wr.awburst;
                    wcnt_d    = 8'd0;
                    w_state_d = W_BURST;
                end
            end
            W_BURST: begin
                if (s_axi_wr.wvalid && wready_q) begin
                    mem_we_c = 1'b1;
                    if (wcnt_q == wlen_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                        waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    end
                end
            end
            W_RESP: begin
                if (s_axi_wr.bready && bvalid_q) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_BURST);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read channel next-state; the R register reloads whenever it is empty or being taken
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rdone_d   = rdone_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        mem_re_c  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi_rd.arvalid && arready_q) begin
                    rid_d     = s_axi_rd.arid;
                    raddr_d   = ADDR_W'(s_axi_rd.araddr);
                    rlen_d    = s_axi_rd.arlen;
                    rsize_d   = s_axi_rd.arsize;
                    rburst_d  = s_axi_rd.arburst;
                    rcnt_d    = 8'd0;
                    rdone_d   = 1'b0;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (!rvalid_q || s_axi_rd.rready) begin
                    if (!rdone_q) begin
                        mem_re_c = 1'b1;
                        rvalid_d = 1'b1;
                        rlast_d  = (rcnt_q == rlen_q);
                        if (rcnt_q == rlen_q) begin
                            rdone_d = 1'b1;
                        end else begin
                            rcnt_d  = rcnt_q + 8'd1;
                            raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                        end
                    end else begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end
                end
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rdone_q   <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rdone_q   <= rdone_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    // RAM array survives reset; same-word read sees the old contents
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (s_axi_wr.wstrb[i]) begin
                    mem_q[waddr_q[ADDR_W-1:OFF_W]][i*8 +: 8] <= s_axi_wr.wdata[i*8 +: 8];
                end
            end
        end
        if (mem_re_c) rdata_q <= mem_q[raddr_q[ADDR_W-1:OFF_W]];
    end

    assign s_axi_wr.awready = awready_q;
    assign s_axi_wr.wready  = wready_q;
    assign s_axi_wr.bvalid  = bvalid_q;
    assign s_axi_wr.bid     = wid_q;
    assign s_axi_wr.bresp   = 2'b00;
    assign s_axi_wr.buser   = '0;

    assign s_axi_rd.arready = arready_q;
    assign s_axi_rd.rvalid  = rvalid_q;
    assign s_axi_rd.rlast   = rlast_q;
    assign s_axi_rd.rid     = rid_q;
    assign s_axi_rd.rdata   = rdata_q;
    assign s_axi_rd.rresp   = 2'b00;
    assign s_axi_rd.ruser   = '0;

    logic unused_c;
    assign unused_c = ^{s_axi_wr.awaddr, s_axi_wr.awlock, s_axi_wr.awcache, s_axi_wr.awprot,
                        s_axi_wr.awqos, s_axi_wr.awregion, s_axi_wr.awuser, s_axi_wr.wlast,
                        s_axi_wr.wuser, s_axi_rd.araddr, s_axi_rd.arlock, s_axi_rd.arcache,
                        s_axi_rd.arprot, s_axi_rd.arqos, s_axi_rd.arregion, s_axi_rd.aruser};
endmodule

// File: tb/tb_taxi_axi_ram.sv
// Directed bench for taxi_axi_ram with queued expected B/R responses
// checked by an independent negedge monitor.
module tb_taxi_axi_ram;
    logic clk;
    logic rst;

    taxi_axi_if #(.DATA_W(32), .ADDR_W(16), .ID_W(8)) axi ();

    taxi_axi_ram #(.ADDR_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axi_wr (axi),
        .s_axi_rd (axi)
    );

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  id;
        logic        last;
        logic [1:0]  resp;
    } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] w_data [16];
    logic [3:0]  w_strb [16];
    logic [31:0] r_exp  [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait expired", name);
    endtask

    // Response monitor: pops expectations on every B/R handshake and checks R stability under stall
    initial begin
        logic        stall_prev;
        logic [40:0] held;
        b_exp_t      be;
        r_exp_t      re;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && axi.rvalid)
                    chk("r_stall_stable", 64'({axi.rdata, axi.rid, axi.rlast}), 64'(held));
                stall_prev = axi.rvalid && !axi.rready;
                held       = {axi.rdata, axi.rid, axi.rlast};
                if (axi.bvalid && axi.bready) begin
                    if (bq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL b_unexpected: got bid=%h with none expected", axi.bid);
                    end else begin
                        be = bq.pop_front();
                        chk("b_resp", 64'({axi.bid, axi.bresp}), 64'(be));
                    end
                end
                if (axi.rvalid && axi.rready) begin
                    if (rq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL r_unexpected: got rdata=%h with none expected", axi.rdata);
                    end else begin
                        re = rq.pop_front();
                        chk("r_beat", 64'({axi.rdata, axi.rid, axi.rlast, axi.rresp}), 64'(re));
                    end
                end
            end
        end
    end

    // abort_after >= 0: assert reset after that many W beats instead of finishing the burst
    task automatic wr_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int abort_after);
        int n;
        if (abort_after < 0) bq.push_back('{id: id, resp: 2'b00});
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size;
        axi.awburst = burst; axi.awvalid = 1'b1;
        n = 0;
        while (!axi.awready && n < 50) begin @(posedge clk); #1; n++; end
        if (!axi.awready) timeout("aw_wait");
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        chk("wready_after_aw", 64'({axi.wready, axi.awready}), 64'(2'b10));
        for (int i = 0; i <= int'(len); i++) begin
            if (i == abort_after) break;
            axi.wdata = w_data[i]; axi.wstrb = w_strb[i]; axi.wlast = (i == int'(len));
            axi.wvalid = 1'b1;
            n = 0;
            while (!axi.wready && n < 50) begin @(posedge clk); #1; n++; end
            if (!axi.wready) timeout("w_wait");
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        if (abort_after < 0) begin
            chk("b_after_last_w", 64'({axi.bvalid, axi.awready, axi.wready}), 64'(3'b100));
            n = 0;
            while (!axi.bvalid && n < 50) begin @(posedge clk); #1; n++; end
            if (!axi.bvalid) timeout("b_wait");
            @(posedge clk); #1;
            chk("awready_after_b", 64'({axi.awready, axi.bvalid}), 64'(2'b10));
        end else begin
            rst = 1'b1;
            repeat (3) begin
                @(posedge clk); #1;
                chk("abort_in_reset", 64'({axi.bvalid, axi.awready, axi.wready, axi.arready}), 64'(4'b0000));
            end
            rst = 1'b0;
            @(posedge clk); #1;
            chk("abort_release", 64'({axi.awready, axi.arready, axi.bvalid}), 64'(3'b110));
            repeat (3) begin
                @(posedge clk); #1;
                chk("abort_no_b", 64'(axi.bvalid), 64'(1'b0));
            end
        end
    endtask

    // stall=1 drives rready with the repeating pattern 1,0,0,1
    task automatic rd_burst(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit stall);
        int         n;
        int         cyc;
        logic       done;
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i <= int'(len); i++)
            rq.push_back('{data: r_exp[i], id: id, last: (i == int'(len)), resp: 2'b00});
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
        axi.arburst = burst; axi.arvalid = 1'b1;
        n = 0;
        while (!axi.arready && n < 50) begin @(posedge clk); #1; n++; end
        if (!axi.arready) timeout("ar_wait");
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        chk("rvalid_T1", 64'({axi.rvalid, axi.arready}), 64'(2'b00));
        cyc = 0;
        axi.rready = stall ? pat[0] : 1'b1;
        @(posedge clk); #1;
        chk("rvalid_T2", 64'(axi.rvalid), 64'(1'b1));
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            chk("arready_busy", 64'(axi.arready), 64'(1'b0));
            done = axi.rvalid && axi.rready && axi.rlast;
            @(posedge clk); #1;
            n++;
            if (!done) begin
                cyc++;
                axi.rready = stall ? pat[cyc % 4] : 1'b1;
            end
        end
        if (!done) timeout("r_last_wait");
        chk("r_end", 64'({axi.rvalid, axi.arready}), 64'(2'b01));
        axi.rready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd2; axi.awburst = 2'b01;
        axi.awlock = 1'b0; axi.awcache = '0; axi.awprot = '0; axi.awqos = '0;
        axi.awregion = '0; axi.awuser = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wuser = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2; axi.arburst = 2'b01;
        axi.arlock = 1'b0; axi.arcache = '0; axi.arprot = '0; axi.arqos = '0;
        axi.arregion = '0; axi.aruser = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b1;

        // Reset values and release timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid,
                                  axi.rlast, axi.bid, axi.rid, axi.bresp, axi.rresp,
                                  axi.buser, axi.ruser}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ready_before_edge", 64'({axi.awready, axi.arready}), 64'(2'b00));
        @(posedge clk); #1;
        chk("ready_after_release", 64'({axi.awready, axi.arready}), 64'(2'b11));

        // INCR write and readback
        w_data[0] = 32'h1111_1111; w_data[1] = 32'h2222_2222;
        w_data[2] = 32'h3333_3333; w_data[3] = 32'h4444_4444;
        for (int i = 0; i < 16; i++) w_strb[i] = 4'hF;
        wr_burst(8'h05, 16'h0100, 8'd3, 3'd2, 2'b01, -1);
        r_exp[0] = 32'h1111_1111; r_exp[1] = 32'h2222_2222;
        r_exp[2] = 32'h3333_3333; r_exp[3] = 32'h4444_4444;
        rd_burst(8'h09, 16'h0100, 8'd3, 3'd2, 2'b01, 1'b0);

        // WRAP from 0x10C: beats land at 0x10C, 0x100, 0x104, 0x108
        for (int i = 0; i < 4; i++) w_data[i] = 32'hA000_0000 + 32'(i);
        wr_burst(8'h06, 16'h010C, 8'd3, 3'd2, 2'b10, -1);
        r_exp[0] = 32'hA000_0001; r_exp[1] = 32'hA000_0002;
        r_exp[2] = 32'hA000_0003; r_exp[3] = 32'hA000_0000;
        rd_burst(8'h0A, 16'h0100, 8'd3, 3'd2, 2'b01, 1'b0);
        r_exp[0] = 32'hA000_0000; r_exp[1] = 32'hA000_0001;
        r_exp[2] = 32'hA000_0002; r_exp[3] = 32'hA000_0003;
        rd_burst(8'h0B, 16'h010C, 8'd3, 3'd2, 2'b10, 1'b0);

        // FIXED burst with one lane per beat into a cleared word
        w_data[0] = 32'h0;
        wr_burst(8'h07, 16'h0200, 8'd0, 3'd2, 2'b01, -1);
        w_data[0] = 32'hDEAD_BEAA; w_strb[0] = 4'h1;
        w_data[1] = 32'hDEAD_BBEF; w_strb[1] = 4'h2;
        w_data[2] = 32'hDECC_BEEF; w_strb[2] = 4'h4;
        wr_burst(8'h08, 16'h0200, 8'd2, 3'd2, 2'b00, -1);
        for (int i = 0; i < 16; i++) w_strb[i] = 4'hF;
        r_exp[0] = 32'h00CC_BBAA; r_exp[1] = 32'h00CC_BBAA;
        rd_burst(8'h0C, 16'h0200, 8'd1, 3'd2, 2'b00, 1'b0);

        // INCR wraps modulo the 16-bit address space
        for (int i = 0; i < 4; i++) w_data[i] = 32'hE000_0000 + 32'(i);
        wr_burst(8'h11, 16'hFFF8, 8'd3, 3'd2, 2'b01, -1);
        r_exp[0] = 32'hE000_0002; r_exp[1] = 32'hE000_0003;
        rd_burst(8'h12, 16'h0000, 8'd1, 3'd2, 2'b01, 1'b0);
        r_exp[0] = 32'hE000_0000; r_exp[1] = 32'hE000_0001;
        rd_burst(8'h13, 16'hFFF8, 8'd1, 3'd2, 2'b01, 1'b0);

        // Eight-beat read with rready stalls
        for (int i = 0; i < 8; i++) w_data[i] = 32'h3030_0000 + 32'(i);
        wr_burst(8'h20, 16'h0300, 8'd7, 3'd2, 2'b01, -1);
        for (int i = 0; i < 8; i++) r_exp[i] = 32'h3030_0000 + 32'(i);
        rd_burst(8'h3C, 16'h0300, 8'd7, 3'd2, 2'b01, 1'b1);

        // Reset after two of four beats: first two words updated, rest untouched
        for (int i = 0; i < 4; i++) w_data[i] = 32'h5555_0000 + 32'(i);
        wr_burst(8'h40, 16'h0400, 8'd3, 3'd2, 2'b01, -1);
        for (int i = 0; i < 4; i++) w_data[i] = 32'h6666_0000 + 32'(i);
        wr_burst(8'h41, 16'h0400, 8'd3, 3'd2, 2'b01, 2);
        r_exp[0] = 32'h6666_0000; r_exp[1] = 32'h6666_0001;
        r_exp[2] = 32'h5555_0002; r_exp[3] = 32'h5555_0003;
        rd_burst(8'h42, 16'h0400, 8'd3, 3'd2, 2'b01, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("b_queue_drained", 64'(bq.size()), 64'(0));
        chk("r_queue_drained", 64'(rq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
